ce_gen_multi: RTL

- Parametrised, lock-qualified multi-channel clock-enable generator. It replaces fixed per-frequency PLL output taps with fractional clock-enables derived from one system clock.
- Sits directly after the system PLL and consumes its locked flag.
- Drives video, CPU and audio clock-enables. Each channel has a runtime-programmable rate, glitch-free rate changes and a global phase resync.

---
 rtl/ce_gen_multi.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ce_gen_multi.sv
// Lock-qualified multi-channel fractional clock-enable generator.
// Each channel wraps a phase accumulator; the wrap carry becomes a one-cycle enable pulse.
//
// state       | meaning
// ST_UNLOCKED | PLL not locked, enables held off, lock counter cleared
// ST_SETTLING | PLL locked, counting consecutive locked cycles
// ST_RUN      | lock qualified, accumulators running, ready high
module ce_gen_multi #(
    parameter int NUM_CH      = 3,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*ACC_W-1:0] inc_in,
    input  logic                    inc_load,
    input  logic                    resync,
    output logic [NUM_CH-1:0]       ce_out,
    output logic [NUM_CH-1:0]       clk_div_out,
    output logic                    ready
);

    localparam int CNT_W = $clog2(LOCK_CYCLES);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_SETTLING,
        ST_RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_lock_cnt;
    logic [CNT_W-1:0]   w_lock_cnt_nxt;

    logic [ACC_W-1:0]   r_acc         [NUM_CH];
    logic [ACC_W-1:0]   r_active_inc  [NUM_CH];
    logic [ACC_W-1:0]   r_pending_inc [NUM_CH];
    logic [NUM_CH-1:0]  r_pending_valid;
    logic [NUM_CH-1:0]  r_ce;
    logic [NUM_CH-1:0]  r_div;

    logic [ACC_W:0]     w_sum         [NUM_CH];
    logic [NUM_CH-1:0]  w_promote;
    logic               w_acc_en;
    logic               w_hold;
    logic               w_direct;

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        if (!pll_locked) begin
            w_state_nxt    = ST_UNLOCKED;
            w_lock_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_UNLOCKED: begin
                    w_state_nxt    = ST_SETTLING;
                    w_lock_cnt_nxt = '0;
                end
                ST_SETTLING: begin
                    if (r_lock_cnt == CNT_W'(LOCK_CYCLES - 2)) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    w_state_nxt = ST_RUN;
                end
                default: begin
                    w_state_nxt    = ST_UNLOCKED;
                    w_lock_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Lock loss while running freezes increment bookkeeping for that edge.
    assign w_hold   = (r_state == ST_RUN) && !pll_locked;
    assign w_acc_en = (r_state == ST_RUN) && pll_locked && !resync;
    assign w_direct = inc_load && resync && !w_hold;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_sum[k]     = {1'b0, r_acc[k]} + {1'b0, r_active_inc[k]};
            w_promote[k] = r_pending_valid[k] && !w_hold &&
                           ((w_acc_en && w_sum[k][ACC_W]) ||
                            (r_state != ST_RUN) ||
                            (r_active_inc[k] == '0) ||
                            resync);
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_state         <= ST_UNLOCKED;
            r_lock_cnt      <= '0;
            r_pending_valid <= '0;
            r_ce            <= '0;
            r_div           <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_acc[k]         <= '0;
                r_active_inc[k]  <= '0;
                r_pending_inc[k] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_acc_en) begin
                    r_acc[k] <= w_sum[k][ACC_W-1:0];
                    r_ce[k]  <= w_sum[k][ACC_W];
                    if (w_sum[k][ACC_W]) begin
                        r_div[k] <= ~r_div[k];
                    end
                end else begin
                    r_acc[k] <= '0;
                    r_ce[k]  <= 1'b0;
                    r_div[k] <= 1'b0;
                end
                // A carry promotes the old pending value; a same-edge load becomes the new pending.
                if (w_direct) begin
                    r_active_inc[k]    <= inc_in[k*ACC_W +: ACC_W];
                    r_pending_valid[k] <= 1'b0;
                end else begin
                    if (w_promote[k]) begin
                        r_active_inc[k]    <= r_pending_inc[k];
                        r_pending_valid[k] <= 1'b0;
                    end
                    if (inc_load) begin
                        r_pending_inc[k]   <= inc_in[k*ACC_W +: ACC_W];
                        r_pending_valid[k] <= 1'b1;
                    end
                end
            end
        end
    end

    assign ce_out      = r_ce;
    assign clk_div_out = r_div;
    assign ready       = (r_state == ST_RUN);

endmodule
